// File: rtl/ram_axil_bridge.sv
// rtl/ram_axil_bridge.sv - CPU data-port to AXI4-Lite master bridge
// One transaction per load/store, with lane steering, wstrb and load extension.
module ram_axil_bridge #(
  parameter logic [2:0] AXI_PROT = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic        cpu_we_i,
  input  logic        cpu_re_i,
  input  logic [2:0]  cpu_size_i,
  output logic [31:0] cpu_rdata_o,
  output logic        hold_flag_o,
  output logic        err_o,
  output logic [31:0] m_awaddr,
  output logic [2:0]  m_awprot,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arprot,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WR    = 3'd1;
  localparam logic [2:0] WRESP = 3'd2;
  localparam logic [2:0] RADDR = 3'd3;
  localparam logic [2:0] RDATA = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]  state;
  logic        aw_done;
  logic        w_done;
  logic [1:0]  lo_q;
  logic [2:0]  size_q;
  logic        req;
  logic        aligned;
  logic [3:0]  wstrb_c;
  logic [31:0] wdata_c;
  logic [31:0] rshift;
  logic [31:0] rext;
  logic        aw_fire;
  logic        w_fire;
  logic        aw_all;
  logic        w_all;

  assign req         = cpu_we_i | cpu_re_i;
  assign hold_flag_o = req & (state != DONE);
  assign m_awprot    = AXI_PROT;
  assign m_arprot    = AXI_PROT;

  // Undefined size codes fall into the misaligned bucket.
  always_comb begin
    aligned = 1'b0;
    case (cpu_size_i)
      3'b000, 3'b100: aligned = 1'b1;
      3'b001, 3'b101: aligned = ~cpu_addr_i[0];
      3'b010:         aligned = (cpu_addr_i[1:0] == 2'b00);
      default:        aligned = 1'b0;
    endcase
  end

  always_comb begin
    case (cpu_size_i[1:0])
      2'b00:   wstrb_c = 4'b0001 << cpu_addr_i[1:0];
      2'b01:   wstrb_c = 4'b0011 << cpu_addr_i[1:0];
      default: wstrb_c = 4'b1111;
    endcase
  end

  assign wdata_c = cpu_wdata_i << {cpu_addr_i[1:0], 3'b000};
  assign rshift  = m_rdata >> {lo_q, 3'b000};

  always_comb begin
    case (size_q)
      3'b000:  rext = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  rext = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  rext = {24'd0, rshift[7:0]};
      3'b101:  rext = {16'd0, rshift[15:0]};
      default: rext = rshift;
    endcase
  end

  assign aw_fire = m_awvalid & m_awready;
  assign w_fire  = m_wvalid & m_wready;
  assign aw_all  = aw_done | aw_fire;
  assign w_all   = w_done | w_fire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      lo_q        <= 2'b00;
      size_q      <= 3'b000;
      cpu_rdata_o <= 32'd0;
      err_o       <= 1'b0;
      m_awaddr    <= 32'd0;
      m_awvalid   <= 1'b0;
      m_wdata     <= 32'd0;
      m_wstrb     <= 4'd0;
      m_wvalid    <= 1'b0;
      m_bready    <= 1'b0;
      m_araddr    <= 32'd0;
      m_arvalid   <= 1'b0;
      m_rready    <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (!aligned) begin
              state <= DONE;
              err_o <= 1'b1;
              if (!cpu_we_i) cpu_rdata_o <= 32'd0;
            end else if (cpu_we_i) begin
              m_awaddr  <= {cpu_addr_i[31:2], 2'b00};
              m_wdata   <= wdata_c;
              m_wstrb   <= wstrb_c;
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
              state     <= WR;
            end else begin
              m_araddr  <= {cpu_addr_i[31:2], 2'b00};
              m_arvalid <= 1'b1;
              lo_q      <= cpu_addr_i[1:0];
              size_q    <= cpu_size_i;
              state     <= RADDR;
            end
          end
        end
        WR: begin
          if (aw_fire) begin
            m_awvalid <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_fire) begin
            m_wvalid <= 1'b0;
            w_done   <= 1'b1;
          end
          if (aw_all && w_all) begin
            m_bready <= 1'b1;
            state    <= WRESP;
          end
        end
        WRESP: begin
          if (m_bvalid) begin
            m_bready <= 1'b0;
            err_o    <= (m_bresp != 2'b00);
            state    <= DONE;
          end
        end
        RADDR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= RDATA;
          end
        end
        RDATA: begin
          if (m_rvalid) begin
            m_rready    <= 1'b0;
            err_o       <= (m_rresp != 2'b00);
            cpu_rdata_o <= (m_rresp != 2'b00) ? 32'd0 : rext;
            state       <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_axil_bridge.sv
// tb/tb_ram_axil_bridge.sv - scoreboard bench for ram_axil_bridge
// Memory-backed AXI-Lite slave with per-channel ready delays and a byte-level reference model.
module tb_ram_axil_bridge;

  logic        clk;
  logic        rst_n;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic [2:0]  cpu_size;
  logic [31:0] cpu_rdata;
  logic        hold_flag;
  logic        err;
  logic [31:0] m_awaddr;
  logic [2:0]  m_awprot;
  logic        m_awvalid;
  logic        s_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        m_bready;
  logic [31:0] m_araddr;
  logic [2:0]  m_arprot;
  logic        m_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        m_rready;

  ram_axil_bridge dut (
    .clk(clk), .rst(rst_n),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata), .cpu_we_i(cpu_we), .cpu_re_i(cpu_re),
    .cpu_size_i(cpu_size), .cpu_rdata_o(cpu_rdata), .hold_flag_o(hold_flag), .err_o(err),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(s_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(s_wready),
    .m_bresp(s_bresp), .m_bvalid(s_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(s_arready),
    .m_rdata(s_rdata), .m_rresp(s_rresp), .m_rvalid(s_rvalid), .m_rready(m_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- slave ----------------
  int          aw_delay = 0;
  int          w_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [1:0]  rresp_cfg = 2'b00;
  logic [31:0] mem [0:255];
  int          aw_cnt, w_cnt, cyc, hs_aw_cyc, hs_w_cyc;
  logic        got_aw, got_w;
  logic [31:0] last_awaddr, last_wdata;
  logic [3:0]  last_wstrb;
  logic        aw_hs, w_hs, aw_now, w_now;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;

  assign s_awready = m_awvalid && (aw_cnt >= aw_delay);
  assign s_wready  = m_wvalid && (w_cnt >= w_delay);
  assign s_arready = m_arvalid;
  assign aw_hs     = m_awvalid && s_awready;
  assign w_hs      = m_wvalid && s_wready;
  assign aw_now    = got_aw || aw_hs;
  assign w_now     = got_w || w_hs;
  assign wr_addr   = aw_hs ? m_awaddr : last_awaddr;
  assign wr_data   = w_hs ? m_wdata : last_wdata;
  assign wr_strb   = w_hs ? m_wstrb : last_wstrb;

  initial for (int i = 0; i < 256; i++) mem[i] = 32'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_bvalid <= 1'b0; s_rvalid <= 1'b0; got_aw <= 1'b0; got_w <= 1'b0;
      aw_cnt <= 0; w_cnt <= 0; s_bresp <= 2'b00; s_rresp <= 2'b00; s_rdata <= 32'd0;
    end else begin
      cyc <= cyc + 1;
      aw_cnt <= aw_hs ? 0 : (m_awvalid ? aw_cnt + 1 : aw_cnt);
      w_cnt  <= w_hs ? 0 : (m_wvalid ? w_cnt + 1 : w_cnt);
      if (aw_hs) begin last_awaddr <= m_awaddr; hs_aw_cyc <= cyc; end
      if (w_hs) begin last_wdata <= m_wdata; last_wstrb <= m_wstrb; hs_w_cyc <= cyc; end
      if (s_bvalid && m_bready) s_bvalid <= 1'b0;
      if (aw_now && w_now) begin
        for (int i = 0; i < 4; i++)
          if (wr_strb[i]) mem[wr_addr[9:2]][8*i +: 8] <= wr_data[8*i +: 8];
        s_bvalid <= 1'b1; s_bresp <= bresp_cfg; got_aw <= 1'b0; got_w <= 1'b0;
      end else begin
        got_aw <= aw_now; got_w <= w_now;
      end
      if (s_rvalid && m_rready) s_rvalid <= 1'b0;
      if (m_arvalid && s_arready) begin
        s_rvalid <= 1'b1; s_rdata <= mem[m_araddr[9:2]]; s_rresp <= rresp_cfg;
      end
    end
  end

  initial cyc = 0;

  // -------- protocol monitor: stability, bready ordering, err only in DONE --------
  int          viol = 0;
  int          ar_hs_cnt = 0;
  logic        pend_aw, pend_w, pend_ar, seen_aw, seen_w;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_aw <= 1'b0; pend_w <= 1'b0; pend_ar <= 1'b0; seen_aw <= 1'b0; seen_w <= 1'b0;
    end else begin
      viol <= viol
            + int'(pend_aw && !(m_awvalid && m_awaddr == p_awaddr))
            + int'(pend_w && !(m_wvalid && m_wdata == p_wdata && m_wstrb == p_wstrb))
            + int'(pend_ar && !(m_arvalid && m_araddr == p_araddr))
            + int'(m_bready && !(seen_aw && seen_w))
            + int'(err && hold_flag);
      pend_aw <= m_awvalid && !s_awready; p_awaddr <= m_awaddr;
      pend_w  <= m_wvalid && !s_wready;   p_wdata <= m_wdata; p_wstrb <= m_wstrb;
      pend_ar <= m_arvalid && !s_arready; p_araddr <= m_araddr;
      if (m_arvalid && s_arready) ar_hs_cnt <= ar_hs_cnt + 1;
      if (s_bvalid && m_bready) begin
        seen_aw <= 1'b0; seen_w <= 1'b0;
      end else begin
        if (aw_hs) seen_aw <= 1'b1;
        if (w_hs) seen_w <= 1'b1;
      end
    end
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct packed { logic [31:0] rdata; logic err; } exp_t;
  exp_t        exp_q [$];
  logic [7:0]  ref_mem [0:1023];
  logic [31:0] exp_hold_val = 32'd0;

  initial for (int i = 0; i < 1024; i++) ref_mem[i] = 8'd0;

  function automatic logic ref_aligned(input logic [2:0] size, input logic [31:0] addr);
    if (size == 3'b000 || size == 3'b100) return 1'b1;
    if (size == 3'b001 || size == 3'b101) return addr % 2 == 0;
    if (size == 3'b010) return addr % 4 == 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] size, input logic [31:0] addr);
    logic [7:0]  b0, b1;
    logic [15:0] h;
    b0 = ref_mem[addr[9:0]];
    b1 = ref_mem[addr[9:0] + 10'd1];
    h  = {b1, b0};
    case (size)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b100:  return {24'd0, b0};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return {ref_mem[addr[9:0] + 10'd3], ref_mem[addr[9:0] + 10'd2], h};
    endcase
  endfunction

  task automatic do_req(input logic we, input logic re, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] size,
                        input int exp_hold_cyc, input string tag);
    exp_t e;
    exp_t got;
    int   n;
    logic al;
    al = ref_aligned(size, addr);
    if (we) begin
      e.rdata = exp_hold_val;
      e.err   = !al || (bresp_cfg != 2'b00);
      if (al) begin
        ref_mem[addr[9:0]] = wdata[7:0];
        if (size[1:0] != 2'b00) ref_mem[addr[9:0] + 10'd1] = wdata[15:8];
        if (size[1:0] == 2'b10) begin
          ref_mem[addr[9:0] + 10'd2] = wdata[23:16];
          ref_mem[addr[9:0] + 10'd3] = wdata[31:24];
        end
      end
    end else begin
      e.err   = !al || (rresp_cfg != 2'b00);
      e.rdata = e.err ? 32'd0 : ref_load(size, addr);
      exp_hold_val = e.rdata;
    end
    exp_q.push_back(e);
    @(negedge clk);
    cpu_addr = addr; cpu_wdata = wdata; cpu_we = we; cpu_re = re; cpu_size = size;
    #1;
    n = 0;
    while (hold_flag && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({tag, "_hold"}, n, exp_hold_cyc);
    got.rdata = cpu_rdata;
    got.err   = err;
    e = exp_q.pop_front();
    check({tag, "_rdata"}, got.rdata, e.rdata);
    check({tag, "_err"}, {31'd0, got.err}, {31'd0, e.err});
    @(negedge clk);
    cpu_we = 1'b0; cpu_re = 1'b0;
    #1;
    check({tag, "_err_end"}, {31'd0, err}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ar_before;
    logic        rwe, rre;
    logic [31:0] raddr;
    logic [2:0]  rsize;
    rst_n = 1'b0;
    cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_we = 1'b0; cpu_re = 1'b0; cpu_size = 3'b000;
    repeat (3) @(negedge clk);
    check("rst_awvalid", {31'd0, m_awvalid}, 32'd0);
    check("rst_wvalid",  {31'd0, m_wvalid}, 32'd0);
    check("rst_arvalid", {31'd0, m_arvalid}, 32'd0);
    check("rst_bready",  {31'd0, m_bready}, 32'd0);
    check("rst_rready",  {31'd0, m_rready}, 32'd0);
    check("rst_rdata",   cpu_rdata, 32'd0);
    check("rst_err",     {31'd0, err}, 32'd0);
    check("rst_awaddr",  m_awaddr, 32'd0);
    check("rst_wstrb",   {28'd0, m_wstrb}, 32'd0);
    check("rst_hold",    {31'd0, hold_flag}, 32'd0);
    rst_n = 1'b1;

    do_req(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 3'b010, 3, "sw");
    check("sw_awaddr", last_awaddr, 32'h100);
    check("sw_wstrb",  {28'd0, last_wstrb}, 32'hF);
    check("sw_mem",    mem[8'h40], 32'hDEADBEEF);

    do_req(1'b1, 1'b0, 32'h103, 32'h000000A5, 3'b000, 3, "sb");
    check("sb_wdata",  last_wdata, 32'hA5000000);
    check("sb_wstrb",  {28'd0, last_wstrb}, 32'h8);
    check("sb_awaddr", last_awaddr, 32'h100);
    check("sb_mem",    mem[8'h40], 32'hA5ADBEEF);

    do_req(1'b1, 1'b0, 32'h100, 32'h0080FF11, 3'b010, 3, "sw2");
    do_req(1'b0, 1'b1, 32'h102, 32'h0, 3'b000, 3, "lb");
    check("lb_val", cpu_rdata, 32'hFFFFFF80);
    do_req(1'b0, 1'b1, 32'h102, 32'h0, 3'b100, 3, "lbu");
    check("lbu_val", cpu_rdata, 32'h00000080);
    do_req(1'b0, 1'b1, 32'h102, 32'h0, 3'b001, 3, "lh");
    check("lh_val", cpu_rdata, 32'h00000080);
    do_req(1'b0, 1'b1, 32'h100, 32'h0, 3'b101, 3, "lhu");
    check("lhu_val", cpu_rdata, 32'h0000FF11);
    do_req(1'b1, 1'b0, 32'h108, 32'h12345678, 3'b010, 3, "sw_keep");
    check("sw_keeps_rdata", cpu_rdata, 32'h0000FF11);

    w_delay = 2; aw_delay = 4;
    do_req(1'b1, 1'b0, 32'h10C, 32'hCAFEF00D, 3'b010, 7, "bp_wfirst");
    check("bp_wfirst_gap", 32'(hs_aw_cyc - hs_w_cyc), 32'd2);
    w_delay = 4; aw_delay = 2;
    do_req(1'b1, 1'b0, 32'h110, 32'h00C0FFEE, 3'b010, 7, "bp_awfirst");
    check("bp_awfirst_gap", 32'(hs_w_cyc - hs_aw_cyc), 32'd2);
    w_delay = 0; aw_delay = 0;
    do_req(1'b0, 1'b1, 32'h10C, 32'h0, 3'b010, 3, "bp_readback");

    ar_before = ar_hs_cnt;
    do_req(1'b0, 1'b1, 32'h102, 32'h0, 3'b010, 1, "lw_mis");
    check("lw_mis_no_ar", ar_hs_cnt, ar_before);

    bresp_cfg = 2'b10;
    do_req(1'b1, 1'b0, 32'h114, 32'h55AA55AA, 3'b010, 3, "sw_slverr");
    bresp_cfg = 2'b00;

    do_req(1'b0, 1'b1, 32'h100, 32'h0, 3'b010, 3, "pre_rst_lw");
    @(negedge clk);
    cpu_addr = 32'h108; cpu_size = 3'b010; cpu_re = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    check("rdata_state_rready", {31'd0, m_rready}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_rready",  {31'd0, m_rready}, 32'd0);
    check("async_rst_arvalid", {31'd0, m_arvalid}, 32'd0);
    check("async_rst_bready",  {31'd0, m_bready}, 32'd0);
    check("async_rst_rdata",   cpu_rdata, 32'd0);
    cpu_re = 1'b0;
    exp_hold_val = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 1'b1, 32'h108, 32'h0, 3'b010, 3, "post_rst_lw");
    check("post_rst_val", cpu_rdata, 32'h12345678);

    for (int k = 0; k < 24; k++) begin
      rwe   = 1'($urandom_range(0, 1));
      rre   = rwe ? 1'($urandom_range(0, 1)) : 1'b1;
      raddr = 32'h100 + 32'($urandom_range(0, 63));
      rsize = 3'($urandom_range(0, 7));
      do_req(rwe, rre, raddr, $urandom, rsize, ref_aligned(rsize, raddr) ? 3 : 1, $sformatf("rnd%0d", k));
    end

    repeat (2) @(negedge clk);
    check("protocol_viol", viol, 0);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_axil_bridge.md
# ram_axil_bridge

Data-side bus bridge sitting directly downstream of the CPU core's EX-stage RAM port (`data_addr`/`data_we`/`data_re`/`data_size`). It converts each single-cycle CPU load/store request into one AXI4-Lite master transaction. It stalls the pipeline through the core's `hold_flag_i` until the transaction completes. It performs byte-lane steering, `wstrb` generation, load extraction and sign extension, so the core's MEM stage receives a ready-to-write-back 32-bit value.

## Interface
Parameters:
- `AXI_PROT`, default 3'b000: constant `awprot`/`arprot` value.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `cpu_addr_i`  in  32  byte address from the core.
- `cpu_wdata_i`  in  32  store data, LSB-aligned.
- `cpu_we_i`  in  1  store request.
- `cpu_re_i`  in  1  load request.
- `cpu_size_i`  in  3  funct3 code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `cpu_rdata_o`  out  32  extended load result to the core's `data_i`.
- `hold_flag_o`  out  1  to the core's `hold_flag_i`.
- `err_o`  out  1  one-cycle pulse on a misaligned access or a non-OKAY response.
- `m_awaddr`  out  32;  `m_awprot`  out  3;  `m_awvalid`  out  1;  `m_awready`  in  1.
- `m_wdata`  out  32;  `m_wstrb`  out  4;  `m_wvalid`  out  1;  `m_wready`  in  1.
- `m_bresp`  in  2;  `m_bvalid`  in  1;  `m_bready`  out  1.
- `m_araddr`  out  32;  `m_arprot`  out  3;  `m_arvalid`  out  1;  `m_arready`  in  1.
- `m_rdata`  in  32;  `m_rresp`  in  2;  `m_rvalid`  in  1;  `m_rready`  out  1.

## Operation
- FSM states: IDLE, WR, WRESP, RADDR, RDATA, DONE.
- Request detection: `req = cpu_we_i | cpu_re_i`. If both are set, the store wins.
- Alignment rules:
  - H/HU requires `addr[0]=0`.
  - W requires `addr[1:0]=00`.
  - Size codes 011, 110 and 111 are treated as misaligned.
- Misaligned request in IDLE:
  - No AXI activity.
  - Go to DONE and pulse `err_o`.
  - Load result is 0.
- Store, aligned: register the address, word-aligned as `{addr[31:2],2'b00}`.
  - `wdata` is `cpu_wdata_i` shifted left by `8*addr[1:0]`.
  - `wstrb` is B: `0001<<addr[1:0]`; H: `0011<<addr[1:0]`; W: `1111`.
  - Assert `awvalid` and `wvalid` together and enter WR.
- WR: `awvalid` and `wvalid` drop independently on their own handshakes. Two flags, `aw_done` and `w_done`, track completion. When both are done, go to WRESP with `bready=1`.
- WRESP: on `bvalid`, go to DONE. A `bresp != 00` pulses `err_o`.
- Load, aligned: drive `araddr` word-aligned, assert `arvalid`, enter RADDR.
  - On `arready`, go to RDATA with `rready=1`.
  - On `rvalid`, shift `rdata` right by `8*addr[1:0]`.
  - Sign- or zero-extend per the size code and register the result into `cpu_rdata_o`.
  - `rresp != 00` pulses `err_o` and loads 0.
  - Then go to DONE.
- DONE: lasts exactly one cycle, then returns to IDLE. The request visible in DONE is the already-served one and is not reissued.
- `cpu_rdata_o` holds its value until the next load completes. Stores do not modify it.
- `hold_flag_o = req & (state != DONE)`. This is combinational, so it is asserted in the same cycle a new request appears.
- AXI valids and the address/data registers are stable from assertion until their handshake.

## Timing
- Reset (async, `rst=0`) values: state IDLE, all `m_*valid`/`m_*ready` 0, `m_awaddr`/`m_araddr`/`m_wdata`/`m_wstrb` 0, `cpu_rdata_o` 0, `err_o` 0. `hold_flag_o` follows its combinational equation.
- Reset asserted mid-transaction abandons the transaction immediately. The slave must also be reset.
- Minimum latencies, with zero-wait slave:
  - Store: IDLE→WR→WRESP→DONE, hold asserted for 3 cycles.
  - Load: IDLE→RADDR→RDATA→DONE, hold asserted for 3 cycles.
- Misaligned access: hold asserted for 1 cycle, `err_o` pulses in the DONE cycle.
- `cpu_rdata_o` is valid from the DONE cycle onward. This covers the core's MEM-stage sample in the following cycle.
- `aw` and `w` handshakes may occur in either order or in the same cycle. `bready` is never asserted before both have completed.
- `err_o` is asserted only in DONE.

## Test plan
- Store word: addr 0x100, data 0xDEADBEEF, zero-wait slave -> `awaddr`=0x100, `wstrb`=1111, hold high for 3 cycles, memory holds 0xDEADBEEF.
- Store byte: addr 0x103, data 0x000000A5 -> `wdata`=0xA5000000, `wstrb`=1000, `awaddr`=0x100.
- Load LB/LBU: addr 0x102, memory word 0x0080FF11 -> LB gives 0xFFFFFF80, LBU gives 0x00000080. LH at 0x102 gives 0x00000080. LHU at 0x100 gives 0x0000FF11.
- Back-pressure on writes:
  - `wready` arrives 2 cycles before `awready`, which arrives at cycle 5 -> each valid drops only on its own handshake, `bready` rises after both.
  - Repeat with `awready` first.
- Errors:
  - LW at 0x102 -> no `arvalid`, 1-cycle hold, `err_o` pulse, result 0.
  - Store with `bresp`=10 -> `err_o` pulse in DONE.
- Async reset asserted in RDATA -> all valids/readies drop without waiting for a clock edge. After release the block is in IDLE and a new load completes normally.
